// File: rtl/pheap_issue_ctrl_pkg.sv
// pheapTypes: shared types for the pipelined heap and its issue front end.
// Holds the root-level operation format, the root status encoding and the
// issue sequencer state enum, plus the default heap depth.
package pheapTypes;

  // Default heap depth and the number of values a full heap of that depth holds
  localparam int LEVELS   = 16;
  localparam int CAPACITY = (1 << LEVELS) - 1;
  localparam int VALUE_W  = 32;

  // A single priority value travelling through the heap
  typedef logic [VALUE_W-1:0] pValue;

  // Operation presented to a heap level
  typedef enum logic [1:0] {
    FREE = 2'd0,
    LEQ  = 2'd1,
    DEQ  = 2'd2
  } opcode_t;

  // Status reported back by a heap level
  typedef enum logic [1:0] {
    DONE       = 2'd0,
    NEXT_LEVEL = 2'd1,
    WAIT       = 2'd2
  } done_t;

  // Operation word handed from one level to the next
  typedef struct packed {
    opcode_t levelOp;
    pValue   value;
  } opArray_t;

  // Issue sequencer states
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    DEQ_WAIT = 2'd2,
    DEQ_HOLD = 2'd3
  } issue_state_t;

  // The "nothing to do" operation word
  localparam opArray_t OP_IDLE = '{levelOp: FREE, value: '0};

  // Builds an operation word from an opcode and a value
  function automatic opArray_t makeOp(input opcode_t code, input pValue v);
    opArray_t o;
    o.levelOp = code;
    o.value   = v;
    return o;
  endfunction

endpackage

// File: rtl/pheap_issue_ctrl_occupancy.sv
// pheap_occupancy: occupancy counter for the heap front end.
// inc_i / dec_i are one-cycle strobes for an issued LEQ / DEQ. The counter
// refuses to move past full or below zero, so it can never wrap.
module pheap_occupancy
  import pheapTypes::*;
#(
  parameter int LEVELS = pheapTypes::LEVELS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [LEVELS:0] count_o,
  output logic            full_o,
  output logic            empty_o
);

  localparam logic [LEVELS:0] FULL_COUNT = {1'b0, {LEVELS{1'b1}}};
  localparam logic [LEVELS:0] ONE        = {{LEVELS{1'b0}}, 1'b1};

  logic [LEVELS:0] count_q;
  logic [LEVELS:0] count_d;

  // Next occupancy: a simultaneous inc and dec cancel out
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != FULL_COUNT)) begin
      count_d = count_q + ONE;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - ONE;
    end
  end

  // Occupancy register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q == FULL_COUNT);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pheap_issue_ctrl.sv
// pheap_issue_ctrl: front-end sequencer of the pipelined heap.
// Takes user enqueue/dequeue requests, issues one LEQ or DEQ per slot into
// the root level (FREE otherwise) while respecting the root's WAIT status and
// a minimum spacing between issued ops, and hands dequeued minima back to
// the user. Defining PHEAP_STATS_EN adds saturating activity counters
// (stat_enq, stat_deq, stat_stall); without it those ports do not exist.
module pheap_issue_ctrl
  import pheapTypes::*;
#(
  parameter int LEVELS    = pheapTypes::LEVELS,
  parameter int ISSUE_GAP = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enq_valid,
  input  logic [31:0]     enq_value,
  output logic            enq_ready,
  input  logic            deq_req,
  output logic            deq_ready,
  output logic            deq_valid,
  output logic [31:0]     deq_value,
  input  logic            deq_ack,
  output logic            deq_err,
  output opArray_t        op_out,
  input  done_t           root_status,
  input  logic            root_value_valid,
  input  logic [31:0]     root_value,
  output logic [LEVELS:0] count,
  output logic            full,
  output logic            empty
`ifdef PHEAP_STATS_EN
  ,
  output logic [31:0]     stat_enq,
  output logic [31:0]     stat_deq,
  output logic [31:0]     stat_stall
`endif
);

  // The gap counter is reloaded as the op is accepted and keeps counting
  // through the ISSUE cycle, so consecutive ops land ISSUE_GAP cycles apart.
  localparam logic [2:0] GAP_LOAD = 3'(ISSUE_GAP - 1);

  issue_state_t state_q, state_d;
  opArray_t     op_q, op_d;
  logic [2:0]   gap_q, gap_d;
  logic         deqValid_q, deqValid_d;
  logic [31:0]  deqValue_q, deqValue_d;
  logic         deqErr_q, deqErr_d;
  logic         readyEn_q, readyEn_d;

  logic         issueWindow;
  logic         enqFire;
  logic         deqFire;
  logic         occFull;
  logic         occEmpty;

  // Decide whether a new request may be taken this cycle; dequeue has priority
  always_comb begin
    issueWindow = (state_q == IDLE) && readyEn_q && (gap_q == '0) &&
                  (root_status != WAIT) && !deqValid_q;
    deq_ready   = issueWindow && !occEmpty;
    enq_ready   = issueWindow && !occFull && !(deq_req && !occEmpty);
    deqFire     = deq_req && deq_ready;
    enqFire     = enq_valid && enq_ready;
  end

  // Sequencer next state and registered outputs
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    gap_d      = (gap_q != '0) ? (gap_q - 3'd1) : gap_q;
    deqValid_d = deqValid_q;
    deqValue_d = deqValue_q;
    deqErr_d   = issueWindow && deq_req && occEmpty;
    readyEn_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (deqFire) begin
          op_d    = makeOp(DEQ, '0);
          gap_d   = GAP_LOAD;
          state_d = ISSUE;
        end else if (enqFire) begin
          op_d    = makeOp(LEQ, enq_value);
          gap_d   = GAP_LOAD;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        op_d    = OP_IDLE;
        state_d = (op_q.levelOp == DEQ) ? DEQ_WAIT : IDLE;
      end
      DEQ_WAIT: begin
        if (root_value_valid) begin
          deqValue_d = root_value;
          deqValid_d = 1'b1;
          state_d    = DEQ_HOLD;
        end
      end
      DEQ_HOLD: begin
        if (deq_ack) begin
          deqValid_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        op_d    = OP_IDLE;
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer registers; readyEn_q keeps the ready outputs low until the
  // first clock after reset is released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= OP_IDLE;
      gap_q      <= '0;
      deqValid_q <= 1'b0;
      deqValue_q <= '0;
      deqErr_q   <= 1'b0;
      readyEn_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      gap_q      <= gap_d;
      deqValid_q <= deqValid_d;
      deqValue_q <= deqValue_d;
      deqErr_q   <= deqErr_d;
      readyEn_q  <= readyEn_d;
    end
  end

  pheap_occupancy #(
    .LEVELS (LEVELS)
  ) u_occupancy (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc_i   (enqFire),
    .dec_i   (deqFire),
    .count_o (count),
    .full_o  (occFull),
    .empty_o (occEmpty)
  );

  assign full      = occFull;
  assign empty     = occEmpty;
  assign op_out    = op_q;
  assign deq_valid = deqValid_q;
  assign deq_value = deqValue_q;
  assign deq_err   = deqErr_q;

`ifdef PHEAP_STATS_EN
  logic [31:0] statEnq_q, statDeq_q, statStall_q;
  logic        stallNow;

  // A request is stalled when something is asking but no issue slot is open
  always_comb begin
    stallNow = (enq_valid || deq_req) && !issueWindow;
  end

  // Saturating activity counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      statEnq_q   <= '0;
      statDeq_q   <= '0;
      statStall_q <= '0;
    end else begin
      if ((state_q == ISSUE) && (op_q.levelOp == LEQ) && (statEnq_q != '1)) begin
        statEnq_q <= statEnq_q + 32'd1;
      end
      if ((state_q == ISSUE) && (op_q.levelOp == DEQ) && (statDeq_q != '1)) begin
        statDeq_q <= statDeq_q + 32'd1;
      end
      if (stallNow && (statStall_q != '1)) begin
        statStall_q <= statStall_q + 32'd1;
      end
    end
  end

  assign stat_enq   = statEnq_q;
  assign stat_deq   = statDeq_q;
  assign stat_stall = statStall_q;
`endif

endmodule

// File: doc/pheap_issue_ctrl.md
Name: pheap_issue_ctrl

Overview:
Front-end sequencer for the pipelined heap. Accepts user enqueue/dequeue requests over valid/ready handshakes. Issues one opArray_t per slot into the root level (LEQ or DEQ, FREE otherwise), honouring the root's done_t status and a minimum issue spacing. Returns dequeued priority values to the user and tracks occupancy (count/full/empty).

Parameters:
LEVELS, pheapTypes::LEVELS (16), heap depth; capacity = 2**LEVELS-1.
ISSUE_GAP, 2, minimum cycles between consecutive non-FREE ops on op_out (legal 1..4).

Ports:
clk  in  1  clock (all logic on rising edge)
rst_n  in  1  asynchronous, active-low reset
enq_valid  in  1  user enqueue request
enq_value  in  32  priority value to enqueue
enq_ready  out  1  enqueue accepted when enq_valid&enq_ready
deq_req  in  1  user dequeue request
deq_ready  out  1  dequeue accepted when deq_req&deq_ready
deq_valid  out  1  dequeued value available; held until deq_ack
deq_value  out  32  dequeued priority value
deq_ack  in  1  user consumes deq_value
deq_err  out  1  one-cycle pulse: dequeue requested while empty
op_out  out  opArray_t  operation to root level (levelOp FREE when idle)
root_status  in  done_t  root level status (DONE/NEXT_LEVEL/WAIT)
root_value_valid  in  1  root presents the removed minimum for a DEQ
root_value  in  32  value removed by the root
count  out  LEVELS+1  current occupancy
full  out  1  count == 2**LEVELS-1
empty  out  1  count == 0

Behaviour:
- Reset (async, rst_n low): state IDLE, op_out = {FREE, 0}, count 0, empty 1, full 0, deq_valid 0, deq_value 0, deq_err 0, gap counter 0, enq_ready/deq_ready 0 until first clock after release.
- States: IDLE, ISSUE, DEQ_WAIT, DEQ_HOLD.
- IDLE: ready outputs asserted only when gap counter == 0, root_status != WAIT, and deq_valid == 0. deq_ready = !empty; enq_ready = !full.
- Simultaneous enq_valid and deq_req: dequeue wins (enq_ready forced 0 that cycle). Dequeue on empty: no op issued, deq_err pulses one cycle, enqueue may be accepted the same cycle.
- ISSUE (one cycle): op_out = {LEQ, enq_value} or {DEQ, 0}; count ±1 at that edge; gap counter loaded with ISSUE_GAP-1. LEQ returns to IDLE; DEQ goes to DEQ_WAIT. op_out returns to FREE the next cycle.
- DEQ_WAIT: waits for root_value_valid; captures root_value into deq_value, sets deq_valid, goes to DEQ_HOLD. A root_value_valid outside DEQ_WAIT is ignored.
- DEQ_HOLD: deq_valid held, value stable until deq_ack; deq_valid clears on that edge → IDLE. deq_ack ignored when deq_valid is 0.
- root_status == WAIT stalls all new issues; a pending op is never dropped.
- count arithmetic LEVELS+1 bits; never wraps (full/empty gating guarantees it).
- Latency: request accepted at edge N → op_out valid in cycle N+1; deq_valid no earlier than one cycle after root_value_valid.

Optional Feature:
PHEAP_STATS_EN: adds outputs stat_enq, stat_deq, stat_stall (32-bit, saturating). These count issued LEQs, issued DEQs, and cycles a request was pending but blocked by gap/WAIT/hold. All reset to 0. Without the macro, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package pheapTypes gains issue_state_t enum {IDLE, ISSUE, DEQ_WAIT, DEQ_HOLD} and a CAPACITY constant.
- It reuses opcode_t, done_t, opArray_t and pValue.
- Sub-module pheap_occupancy: count/full/empty register, with inc/dec strobes.

Test Plan:
- Reset mid-DEQ_WAIT (rst_n low while awaiting root_value_valid) → op_out FREE, count 0, deq_valid 0 immediately, without waiting for a clock.
- Enqueue 5, 3, 9 with ISSUE_GAP=2 and enq_valid held → LEQ ops on op_out exactly 2 cycles apart; count 3; empty 0.
- Dequeue with model root returning 3 two cycles after DEQ → deq_valid=1, deq_value=3 held until deq_ack, count 2.
- enq_valid and deq_req together at count 1 → DEQ issued, enq_ready 0 that cycle, LEQ issued after gap.
- deq_req at count 0 → deq_err one-cycle pulse, op_out stays FREE, count stays 0.
- LEVELS=2: fill to 3 → full 1, enq_ready 0. root_status=WAIT for 4 cycles → no op issued; issue resumes the first cycle after WAIT deasserts.
